// File: rtl/cim_wload.sv
// -----------------------------------------------------------------------------
// cim_wload -- weight-load transmitter for the CIM macro array write port.
//
// Accepts a valid/ready stream of WBITS-wide weights, packs NWPB of them into
// the NWPB*WBITS-bit D bus and fires one one-hot WA write strobe per block,
// walking all NBLK blocks of the bank selected at start.
//
// Ports
//   clk      in   1            clock, rising edge
//   rstn     in   1            synchronous active-low reset
//   start    in   1            begin a bank load (honoured only when idle)
//   bank     in   1            target bank latched at start (0 = mem_0)
//   abort    in   1            cancel the load in progress
//   w_valid  in   1            weight word valid
//   w_data   in   WBITS        weight word
//   w_ready  out  1            weight word accepted on w_valid & w_ready
//   D        out  NWPB*WBITS   packed block data to the array
//   WA       out  NBLK         one-hot block write strobe (0 = no write)
//   cima     out  1            array bank select, ~latched bank
//   busy     out  1            load in progress
//   done     out  1            one-cycle pulse after the last block write
// -----------------------------------------------------------------------------
module cim_wload #(
  parameter int unsigned NBLK  = 9,
  parameter int unsigned NWPB  = 16,
  parameter int unsigned WBITS = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    bank,
  input  logic                    abort,
  input  logic                    w_valid,
  input  logic [WBITS-1:0]        w_data,
  output logic                    w_ready,
  output logic [NWPB*WBITS-1:0]   D,
  output logic [NBLK-1:0]         WA,
  output logic                    cima,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW = NWPB * WBITS;
  localparam int unsigned IW = (NWPB > 1) ? $clog2(NWPB) : 1;
  localparam int unsigned BW = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(NWPB - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(NBLK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   d_q, d_d;
  logic [NBLK-1:0] wa_q, wa_d;
  logic            cima_q, cima_d;
  logic            w_ready_q, w_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    d_d     = d_q;
    wa_d    = '0;          // a strobe lives for exactly one cycle
    cima_d  = cima_q;

    unique case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort has nothing to cancel here
        if (start) begin
          cima_d  = ~bank;
          blk_d   = '0;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (abort) begin
          // abort wins over a same-edge accept: the word is dropped
          blk_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (w_valid) begin
          for (int unsigned k = 0; k < NWPB; k++) begin
            if (idx_q == IW'(k)) begin
              d_d[k*WBITS +: WBITS] = w_data;
            end
          end
          if (idx_q == IDX_LAST) begin
            wa_d    = NBLK'(1) << blk_q;
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_WRITE: begin
        if (abort) begin
          blk_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (blk_q == BLK_LAST) begin
          blk_d   = '0;
          state_d = S_DONE;
        end else begin
          blk_d   = blk_q + BW'(1);
          state_d = S_FILL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode
    w_ready_d = (state_d == S_FILL);
    busy_d    = (state_d == S_FILL) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      blk_q     <= '0;
      idx_q     <= '0;
      d_q       <= '0;
      wa_q      <= '0;
      cima_q    <= 1'b0;
      w_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      idx_q     <= idx_d;
      d_q       <= d_d;
      wa_q      <= wa_d;
      cima_q    <= cima_d;
      w_ready_q <= w_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_ready = w_ready_q;
  assign D       = d_q;
  assign WA      = wa_q;
  assign cima    = cima_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cim_wload.sv
// Bench for cim_wload: randomized weight streams against a transaction-level
// model (accept counting, word buffer) plus hand-computed expectations.
module tb_cim_wload;

  localparam int NBLK  = 9;
  localparam int NWPB  = 16;
  localparam int WBITS = 12;
  localparam int DW    = NWPB * WBITS;
  localparam int NW    = NBLK * NWPB;

  logic              clk = 1'b0;
  logic              rstn, start, bank, abort, w_valid;
  logic [WBITS-1:0]  w_data;
  logic              w_ready, cima, busy, done;
  logic [DW-1:0]     D;
  logic [NBLK-1:0]   WA;

  cim_wload #(.NBLK(NBLK), .NWPB(NWPB), .WBITS(WBITS)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bank(bank), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .D(D), .WA(WA),
    .cima(cima), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit               m_active = 0;   // a load is in progress
  bit               m_wr     = 0;   // current cycle is a block write
  bit               m_done   = 0;
  bit               m_cima   = 0;
  int               m_n      = 0;   // words accepted in this load
  int               m_acc    = 0;   // words accepted overall
  logic [WBITS-1:0] m_words [NWPB];

  initial for (int k = 0; k < NWPB; k++) m_words[k] = '0;

  always @(posedge clk) begin : model
    bit pd;
    pd = m_done;
    m_done = 0;
    if (!rstn) begin
      m_active = 0; m_wr = 0; m_n = 0; m_cima = 0;
      for (int k = 0; k < NWPB; k++) m_words[k] = '0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 0; m_wr = 0; m_n = 0;
      end else if (m_wr) begin
        m_wr = 0;
        if (m_n == NW) begin m_active = 0; m_done = 1; end
      end else if (w_valid) begin
        m_words[m_n % NWPB] = w_data;
        m_n++;
        m_acc++;
        if (m_n % NWPB == 0) m_wr = 1;
      end
    end else if (!pd && start) begin
      m_active = 1; m_n = 0; m_cima = ~bank;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;
  bit chk_en = 0, t1_mode = 0, have_prev = 0;
  int cyc = 0, strobe_cnt = 0, done_cnt = 0, last_b = -1;
  int last_strobe_cyc = 0, last_strobe_acc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [NBLK-1:0] exp_wa;
    logic [DW-1:0]   exp_d, lit;
    int b;
    cyc++;
    if (chk_en) begin
      exp_wa = m_wr ? (NBLK'(1) << ((m_n - 1) / NWPB)) : '0;
      for (int k = 0; k < NWPB; k++) exp_d[k*WBITS +: WBITS] = m_words[k];
      check("w_ready", DW'(w_ready), DW'(m_active && !m_wr));
      check("busy",    DW'(busy),    DW'(m_active));
      check("done",    DW'(done),    DW'(m_done));
      check("cima",    DW'(cima),    DW'(m_cima));
      check("WA",      DW'(WA),      DW'(exp_wa));
      check("D",       D,            exp_d);
      if (WA != '0) begin
        strobe_cnt++;
        b = -1;
        for (int k = 0; k < NBLK; k++) if (WA[k]) b = k;
        last_b = b;
        if (t1_mode) begin
          for (int k = 0; k < NWPB; k++) lit[k*WBITS +: WBITS] = WBITS'(NWPB * b + k);
          check("t1_block_data", D, lit);
        end
        if (have_prev) begin
          check("accepts_between_strobes", DW'(m_acc - last_strobe_acc), DW'(NWPB));
          if (t1_mode) check("t1_strobe_gap", DW'(cyc - last_strobe_cyc), DW'(NWPB + 1));
        end
        have_prev = 1;
        last_strobe_cyc = cyc;
        last_strobe_acc = m_acc;
      end
      if (done) begin
        done_cnt++;
        if (t1_mode) check("t1_done_latency", DW'(cyc - last_strobe_cyc), DW'(1));
      end
      if (!m_active) have_prev = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input bit b);
    start = 1'b1; bank = b;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random gaps
  task automatic feed(input int nacc, input int mode, input bit seq);
    int s, bud, ph;
    s = m_acc; bud = 0; ph = 0;
    while (m_acc - s < nacc && bud < 4000) begin
      w_data = seq ? WBITS'(m_acc - s) : WBITS'($urandom);
      case (mode)
        0:       w_valid = 1'b1;
        1:       w_valid = (ph % 2 == 0);
        default: w_valid = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
      tick();
      bud++;
    end
    w_valid = 1'b0;
    if (bud >= 4000) check("feed_timeout", DW'(m_acc - s), DW'(nacc));
  endtask

  task automatic wait_done();
    int bud;
    bud = 0;
    while (!m_done && bud < 400) begin tick(); bud++; end
    if (bud >= 400) check("done_timeout", DW'(m_done), DW'(1));
    tick(); tick();
  endtask

  int s0, d0;

  initial begin
    rstn = 1'b0; start = 1'b0; bank = 1'b0; abort = 1'b0;
    w_valid = 1'b0; w_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_outputs", DW'({w_ready, busy, done, cima, WA}), DW'(0));
    check("reset_D", D, DW'(0));
    rstn = 1'b1;
    tick();

    // 1: bank 0, sequential words back-to-back
    t1_mode = 1; s0 = strobe_cnt; d0 = done_cnt;
    do_start(1'b0);
    check("t1_cima", DW'(cima), DW'(1));
    feed(NW, 0, 1'b1);
    wait_done();
    t1_mode = 0;
    check("t1_strobes", DW'(strobe_cnt - s0), DW'(9));
    check("t1_dones", DW'(done_cnt - d0), DW'(1));
    check("t1_idle", DW'(busy), DW'(0));

    // 2: bank 1, toggling valid
    s0 = strobe_cnt; d0 = done_cnt;
    do_start(1'b1);
    check("t2_cima", DW'(cima), DW'(0));
    feed(NW, 1, 1'b0);
    wait_done();
    check("t2_strobes", DW'(strobe_cnt - s0), DW'(9));
    check("t2_dones", DW'(done_cnt - d0), DW'(1));

    // 3: abort on the 5th accept of block 3, then restart
    s0 = strobe_cnt; d0 = done_cnt;
    do_start(1'b0);
    feed(3 * NWPB + 4, 0, 1'b1);
    w_valid = 1'b1; abort = 1'b1;
    tick();
    w_valid = 1'b0; abort = 1'b0;
    check("t3_busy_after_abort", DW'(busy), DW'(0));
    tick(); tick();
    check("t3_strobes", DW'(strobe_cnt - s0), DW'(3));
    check("t3_no_done", DW'(done_cnt - d0), DW'(0));
    s0 = strobe_cnt;
    do_start(1'b0);
    feed(NWPB, 0, 1'b1);
    tick();
    check("t3_restart_strobes", DW'(strobe_cnt - s0), DW'(1));
    check("t3_restart_block", DW'(last_b), DW'(0));
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // 4: start pulsed during block 4 fill is ignored
    s0 = strobe_cnt; d0 = done_cnt;
    do_start(1'b0);
    feed(4 * NWPB + 3, 0, 1'b0);
    start = 1'b1; bank = 1'b1;
    tick();
    start = 1'b0;
    feed(NW - (4 * NWPB + 3), 0, 1'b0);
    wait_done();
    check("t4_strobes", DW'(strobe_cnt - s0), DW'(9));
    check("t4_dones", DW'(done_cnt - d0), DW'(1));
    check("t4_cima_held", DW'(cima), DW'(1));

    // 5: reset right after the WA[6] strobe
    do_start(1'b0);
    feed(7 * NWPB, 2, 1'b0);
    check("t5_wa6", DW'(WA), DW'(1 << 6));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t5_reset_outputs", DW'({w_ready, busy, done, cima, WA}), DW'(0));
    check("t5_reset_D", D, DW'(0));
    s0 = strobe_cnt;
    w_valid = 1'b1;
    repeat (20) tick();
    w_valid = 1'b0;
    check("t5_no_strobe_without_start", DW'(strobe_cnt - s0), DW'(0));
    do_start(1'b1);
    feed(NWPB, 0, 1'b0);
    tick();
    check("t5_restart_strobes", DW'(strobe_cnt - s0), DW'(1));
    check("t5_restart_block", DW'(last_b), DW'(0));
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // 6: 20 full loads with random gaps and data
    s0 = strobe_cnt; d0 = done_cnt;
    for (int n = 0; n < 20; n++) begin
      do_start(1'($urandom_range(0, 1)));
      feed(NW, 2, 1'b0);
      wait_done();
    end
    check("t6_dones", DW'(done_cnt - d0), DW'(20));
    check("t6_strobes", DW'(strobe_cnt - s0), DW'(180));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
